// File: rtl/gtxe2_chnl_cpll_lockdet_if.sv
// Lock-detect bundle: per-channel enables, clock toggles and results.
// Master drives the inputs, slave is the detector.
interface gtxe2_chnl_cpll_lockdet_if #(
  parameter int NCH   = 1,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]       lock_en;
  logic [NCH-1:0]       pd;
  logic [NCH-1:0]       ref_tgl;
  logic [NCH-1:0]       fb_tgl;
  logic [NCH-1:0]       lock;
  logic [NCH-1:0]       refclk_lost;
  logic [NCH-1:0]       fbclk_lost;
  logic                 win_done;
  logic [NCH*CNT_W-1:0] ref_cnt_last;
  logic [NCH*CNT_W-1:0] fb_cnt_last;

  modport master (
    output lock_en, pd, ref_tgl, fb_tgl,
    input  lock, refclk_lost, fbclk_lost,
    input  win_done, ref_cnt_last, fb_cnt_last
  );

  modport slave (
    input  lock_en, pd, ref_tgl, fb_tgl,
    output lock, refclk_lost, fbclk_lost,
    output win_done, ref_cnt_last, fb_cnt_last
  );
endinterface

// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// CPLL lock / clock-loss detector: counts ref and fb toggle
// events per window and locks on sustained frequency agreement.
module gtxe2_chnl_cpll_lockdet #(
  parameter int NCH            = 1,
  parameter int CNT_W          = 16,
  parameter int WINDOW         = 1024,
  parameter int TOL            = 2,
  parameter int MIN_CNT        = 1,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic CPLLLOCKDETCLK,
  input  logic CPLLRESET_N,
  gtxe2_chnl_cpll_lockdet_if.slave bus
);

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int BW = $clog2(UNLOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_OFF,
    S_ARM,
    S_ACQ,
    S_LCK
  } st_t;

  logic [TW-1:0] r_tmr;
  logic          w_wd;

  assign w_wd         = (r_tmr == TW'(WINDOW - 1));
  assign bus.win_done = w_wd;

  // Shared free-running window timer
  always_ff @(posedge CPLLLOCKDETCLK or negedge CPLLRESET_N) begin
    if (!CPLLRESET_N) r_tmr <= '0;
    else              r_tmr <= w_wd ? '0 : r_tmr + 1'b1;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [2:0]       r_rs, r_fs;
    logic             w_rev, w_fev;
    logic [CNT_W-1:0] r_rc, r_fc;
    logic [CNT_W-1:0] w_rn, w_fn;
    logic [CNT_W:0]   w_df, w_ad;
    logic             w_rlo, w_flo, w_match, w_off;
    st_t              r_st;
    logic [GW-1:0]    r_good;
    logic [BW-1:0]    r_bad;
    logic             r_lock, r_rlost, r_flost;
    logic [CNT_W-1:0] r_rlast, r_flast;

    assign w_rev   = r_rs[1] ^ r_rs[2];
    assign w_fev   = r_fs[1] ^ r_fs[2];
    assign w_rn    = (r_rc == CMAX) ? CMAX : r_rc + CNT_W'(w_rev);
    assign w_fn    = (r_fc == CMAX) ? CMAX : r_fc + CNT_W'(w_fev);
    assign w_df    = {1'b0, w_rn} - {1'b0, w_fn};
    assign w_ad    = w_df[CNT_W] ? (~w_df + 1'b1) : w_df;
    assign w_rlo   = (w_rn < CNT_W'(MIN_CNT));
    assign w_flo   = (w_fn < CNT_W'(MIN_CNT));
    assign w_match = !w_rlo && !w_flo && (w_ad <= (CNT_W+1)'(TOL));
    assign w_off   = !bus.lock_en[c] || bus.pd[c];

    assign bus.lock[c]        = r_lock;
    assign bus.refclk_lost[c] = r_rlost;
    assign bus.fbclk_lost[c]  = r_flost;
    assign bus.ref_cnt_last[c*CNT_W +: CNT_W] = r_rlast;
    assign bus.fb_cnt_last[c*CNT_W +: CNT_W]  = r_flast;

    // Toggle synchronizers with history stage, always running
    always_ff @(posedge CPLLLOCKDETCLK or negedge CPLLRESET_N) begin
      if (!CPLLRESET_N) begin
        r_rs <= '0;
        r_fs <= '0;
      end else begin
        r_rs <= {r_rs[1:0], bus.ref_tgl[c]};
        r_fs <= {r_fs[1:0], bus.fb_tgl[c]};
      end
    end

    // Per-channel event counters and lock FSM
    always_ff @(posedge CPLLLOCKDETCLK or negedge CPLLRESET_N) begin
      if (!CPLLRESET_N) begin
        r_st    <= S_OFF;
        r_rc    <= '0;
        r_fc    <= '0;
        r_good  <= '0;
        r_bad   <= '0;
        r_lock  <= 1'b0;
        r_rlost <= 1'b0;
        r_flost <= 1'b0;
        r_rlast <= '0;
        r_flast <= '0;
      end else if (w_off) begin
        r_st    <= S_OFF;
        r_rc    <= '0;
        r_fc    <= '0;
        r_good  <= '0;
        r_bad   <= '0;
        r_lock  <= 1'b0;
        r_rlost <= 1'b0;
        r_flost <= 1'b0;
      end else begin
        r_rc <= w_wd ? '0 : w_rn;
        r_fc <= w_wd ? '0 : w_fn;
        unique case (r_st)
          S_OFF: begin
            r_st <= S_ARM;
            r_rc <= '0;
            r_fc <= '0;
          end
          S_ARM: begin
            if (w_wd) r_st <= S_ACQ;
          end
          S_ACQ: begin
            if (w_wd) begin
              r_rlast <= w_rn;
              r_flast <= w_fn;
              r_rlost <= w_rlo;
              r_flost <= w_flo;
              if (!w_match) begin
                r_good <= '0;
              end else if (r_good == GW'(LOCK_WINDOWS - 1)) begin
                r_st   <= S_LCK;
                r_lock <= 1'b1;
                r_good <= '0;
                r_bad  <= '0;
              end else begin
                r_good <= r_good + 1'b1;
              end
            end
          end
          S_LCK: begin
            if (w_wd) begin
              r_rlast <= w_rn;
              r_flast <= w_fn;
              r_rlost <= w_rlo;
              r_flost <= w_flo;
              if (w_match) begin
                r_bad <= '0;
              end else if (r_bad == BW'(UNLOCK_WINDOWS - 1)) begin
                r_st   <= S_ACQ;
                r_lock <= 1'b0;
                r_good <= '0;
                r_bad  <= '0;
              end else begin
                r_bad <= r_bad + 1'b1;
              end
            end
          end
          default: r_st <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gtxe2_chnl_cpll_lockdet.sv
// Directed bench for the CPLL lock detector, two channels,
// 64-cycle window, toggles placed at fixed window phases.
module tb_gtxe2_chnl_cpll_lockdet;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gtxe2_chnl_cpll_lockdet_if #(.NCH(2), .CNT_W(8)) bus ();

  gtxe2_chnl_cpll_lockdet #(
    .NCH(2), .CNT_W(8), .WINDOW(64), .TOL(2), .MIN_CNT(1),
    .LOCK_WINDOWS(4), .UNLOCK_WINDOWS(2)
  ) dut (
    .CPLLLOCKDETCLK(clk),
    .CPLLRESET_N(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Reference window phase, expected to track the DUT timer
  logic [5:0] ph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= '0;
    else        ph <= ph + 6'd1;
  end

  // Events per window per channel: 0..20 spaced by 3, 64 = every clock
  int ref_n[2];
  int fb_n[2];
  logic [1:0] rt = '0;
  logic [1:0] ft = '0;
  assign bus.ref_tgl = rt;
  assign bus.fb_tgl  = ft;

  function automatic bit hit(int n, int p);
    return (n == 64) || ((p % 3 == 1) && (p / 3 < n));
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (hit(ref_n[c], int'(ph))) rt[c] = ~rt[c];
      if (hit(fb_n[c], int'(ph)))  ft[c] = ~ft[c];
    end
  end

  task automatic wins(int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      @(negedge clk);
      while (ph != 6'd0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (ph != 6'd0) begin
        $display("FAIL wins_timeout ph=%0d want=0", ph);
        bad++; total++;
      end
    end
  endtask

  task automatic go_ph(int p);
    int k = 0;
    @(negedge clk);
    while (int'(ph) != p && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (int'(ph) != p) begin
      $display("FAIL go_ph_timeout ph=%0d want=%0d", ph, p);
      bad++; total++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.lock_en = 2'b00;
    bus.pd = 2'b00;
    for (int c = 0; c < 2; c++) begin
      ref_n[c] = 0;
      fb_n[c] = 0;
    end
    #2;
    total++;
    if (bus.lock !== 2'b00 || bus.refclk_lost !== 2'b00 ||
        bus.fbclk_lost !== 2'b00) begin
      $display("FAIL rst_flags got=%b%b%b want=000000",
               bus.lock, bus.refclk_lost, bus.fbclk_lost);
      bad++;
    end
    total++;
    if (bus.ref_cnt_last !== 16'h0 || bus.fb_cnt_last !== 16'h0 ||
        bus.win_done !== 1'b0) begin
      $display("FAIL rst_cnt got=%h %h %b want=0000 0000 0",
               bus.ref_cnt_last, bus.fb_cnt_last, bus.win_done);
      bad++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go_ph(63);
    total++;
    if (bus.win_done !== 1'b1) begin
      $display("FAIL wd_hi got=%b want=1", bus.win_done);
      bad++;
    end
    @(negedge clk);
    total++;
    if (bus.win_done !== 1'b0) begin
      $display("FAIL wd_lo got=%b want=0", bus.win_done);
      bad++;
    end
  endtask

  task automatic test_lock_acquire();
    for (int c = 0; c < 2; c++) begin
      ref_n[c] = 16;
      fb_n[c] = 16;
    end
    go_ph(20);
    bus.lock_en = 2'b11;
    wins(1);
    total++;
    if (bus.lock !== 2'b00) begin
      $display("FAIL acq_arm lock=%b want=00", bus.lock);
      bad++;
    end
    wins(1);
    total++;
    if (bus.ref_cnt_last !== 16'h1010 || bus.fb_cnt_last !== 16'h1010) begin
      $display("FAIL acq_cnt got=%h %h want=1010 1010",
               bus.ref_cnt_last, bus.fb_cnt_last);
      bad++;
    end
    wins(2);
    go_ph(63);
    total++;
    if (bus.lock !== 2'b00) begin
      $display("FAIL acq_pre lock=%b want=00", bus.lock);
      bad++;
    end
    @(negedge clk);
    total++;
    if (bus.lock !== 2'b11 || bus.refclk_lost !== 2'b00 ||
        bus.fbclk_lost !== 2'b00) begin
      $display("FAIL acq_lock got=%b %b %b want=11 00 00",
               bus.lock, bus.refclk_lost, bus.fbclk_lost);
      bad++;
    end
  endtask

  task automatic test_fb_loss();
    fb_n[0] = 0;
    wins(1);
    total++;
    if (bus.fbclk_lost !== 2'b01 || bus.lock !== 2'b11 ||
        bus.fb_cnt_last[7:0] !== 8'd0) begin
      $display("FAIL fbl_1 got=%b %b %0d want=01 11 0",
               bus.fbclk_lost, bus.lock, bus.fb_cnt_last[7:0]);
      bad++;
    end
    wins(1);
    total++;
    if (bus.lock !== 2'b10 || bus.fbclk_lost !== 2'b01) begin
      $display("FAIL fbl_2 got=%b %b want=10 01",
               bus.lock, bus.fbclk_lost);
      bad++;
    end
    fb_n[0] = 16;
    wins(1);
    total++;
    if (bus.fbclk_lost !== 2'b00 || bus.lock !== 2'b10) begin
      $display("FAIL fbl_3 got=%b %b want=00 10",
               bus.fbclk_lost, bus.lock);
      bad++;
    end
    wins(2);
    total++;
    if (bus.lock !== 2'b10) begin
      $display("FAIL fbl_4 lock=%b want=10", bus.lock);
      bad++;
    end
    wins(1);
    total++;
    if (bus.lock !== 2'b11) begin
      $display("FAIL fbl_relock lock=%b want=11", bus.lock);
      bad++;
    end
  endtask

  task automatic test_tolerance();
    fb_n[0] = 19;
    wins(1);
    total++;
    if (bus.fb_cnt_last[7:0] !== 8'd19 || bus.lock !== 2'b11) begin
      $display("FAIL tol_19 got=%0d %b want=19 11",
               bus.fb_cnt_last[7:0], bus.lock);
      bad++;
    end
    wins(4);
    total++;
    if (bus.lock !== 2'b10 || bus.refclk_lost !== 2'b00 ||
        bus.fbclk_lost !== 2'b00) begin
      $display("FAIL tol_nolock got=%b %b %b want=10 00 00",
               bus.lock, bus.refclk_lost, bus.fbclk_lost);
      bad++;
    end
    fb_n[0] = 18;
    wins(3);
    total++;
    if (bus.lock !== 2'b10) begin
      $display("FAIL tol_18_pre lock=%b want=10", bus.lock);
      bad++;
    end
    wins(1);
    total++;
    if (bus.lock !== 2'b11 || bus.fb_cnt_last[7:0] !== 8'd18) begin
      $display("FAIL tol_18 got=%b %0d want=11 18",
               bus.lock, bus.fb_cnt_last[7:0]);
      bad++;
    end
  endtask

  task automatic test_disable_on_wd();
    fb_n[0] = 0;
    go_ph(63);
    bus.lock_en = 2'b10;
    @(negedge clk);
    total++;
    if (bus.lock !== 2'b10 || bus.fbclk_lost !== 2'b00 ||
        bus.fb_cnt_last[7:0] !== 8'd18) begin
      $display("FAIL dis_wd got=%b %b %0d want=10 00 18",
               bus.lock, bus.fbclk_lost, bus.fb_cnt_last[7:0]);
      bad++;
    end
    fb_n[0] = 16;
    bus.lock_en = 2'b11;
    wins(4);
    total++;
    if (bus.lock !== 2'b10) begin
      $display("FAIL dis_pre lock=%b want=10", bus.lock);
      bad++;
    end
    wins(1);
    total++;
    if (bus.lock !== 2'b11) begin
      $display("FAIL dis_relock lock=%b want=11", bus.lock);
      bad++;
    end
  endtask

  task automatic test_async_reset();
    go_ph(30);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.lock !== 2'b00 || bus.win_done !== 1'b0 ||
        bus.ref_cnt_last !== 16'h0 || bus.fb_cnt_last !== 16'h0) begin
      $display("FAIL ares_clr got=%b %b %h %h want=00 0 0000 0000",
               bus.lock, bus.win_done, bus.ref_cnt_last, bus.fb_cnt_last);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wins(4);
    go_ph(63);
    total++;
    if (bus.win_done !== 1'b1 || bus.lock !== 2'b00) begin
      $display("FAIL ares_pre got=%b %b want=1 00",
               bus.win_done, bus.lock);
      bad++;
    end
    @(negedge clk);
    total++;
    if (bus.lock !== 2'b11) begin
      $display("FAIL ares_relock lock=%b want=11", bus.lock);
      bad++;
    end
  endtask

  task automatic test_two_ch_fast();
    ref_n[0] = 64;
    fb_n[0] = 64;
    ref_n[1] = 0;
    fb_n[1] = 64;
    wins(2);
    total++;
    if (bus.lock !== 2'b01 || bus.refclk_lost !== 2'b10 ||
        bus.fbclk_lost !== 2'b00) begin
      $display("FAIL fast_flags got=%b %b %b want=01 10 00",
               bus.lock, bus.refclk_lost, bus.fbclk_lost);
      bad++;
    end
    total++;
    if (bus.ref_cnt_last !== 16'h0040 || bus.fb_cnt_last !== 16'h4040) begin
      $display("FAIL fast_cnt got=%h %h want=0040 4040",
               bus.ref_cnt_last, bus.fb_cnt_last);
      bad++;
    end
  endtask

  task automatic test_pd();
    go_ph(10);
    bus.pd = 2'b01;
    @(negedge clk);
    total++;
    if (bus.lock !== 2'b00 || bus.refclk_lost !== 2'b10) begin
      $display("FAIL pd got=%b %b want=00 10",
               bus.lock, bus.refclk_lost);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_fb_loss();
    test_tolerance();
    test_disable_on_wd();
    test_async_reset();
    test_two_ch_fast();
    test_pd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
